// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with a two-entry skid buffer and synchronous flush.
module pipe_skid_reg #(
    parameter int CTRL_W          = 9,
    parameter int DATA_W          = 133,
    parameter bit FLUSH_ZERO_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    // Encoding is {main_v, skid_v}; the skid entry is only ever valid behind a valid main.
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              main_v, skid_v, accept, take;
    assign main_v    = state_q[1];
    assign skid_v    = state_q[0];
    assign in_ready  = state_q != FULL;
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (FLUSH_ZERO_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d     = ONE;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
                ONE: if (accept && take) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (take) begin
                    state_d = EMPTY;
                end
                FULL: if (take) begin
                    state_d     = ONE;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end
endmodule
